// File: rtl/lane_rotator_pipe.sv
// Pipelined lane permuter: rotates or zero-fill shifts NUM_DATA lanes by a per-beat
// offset through a log2 barrel, one register per stage, with a valid/ready handshake.
module lane_rotator_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA   = 4,
  parameter int CTRL_WIDTH = $clog2(NUM_DATA)
) (
  input  logic                           ACLK,
  input  logic                           RESET,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] DATA_IN,
  input  logic [CTRL_WIDTH-1:0]          CTRL_IN,
  input  logic [1:0]                     MODE_IN,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [DATA_WIDTH*NUM_DATA-1:0] DATA_OUT,
  output logic [NUM_DATA-1:0]            LANE_MASK
);

  localparam int BW = DATA_WIDTH * NUM_DATA;
  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;

  logic                  advance;

  logic                  valid_q [CTRL_WIDTH];
  logic                  valid_d [CTRL_WIDTH];
  logic [BW-1:0]         data_q  [CTRL_WIDTH];
  logic [BW-1:0]         data_d  [CTRL_WIDTH];
  logic [NUM_DATA-1:0]   mask_q  [CTRL_WIDTH];
  logic [NUM_DATA-1:0]   mask_d  [CTRL_WIDTH];
  logic [CTRL_WIDTH-1:0] ctrl_q  [CTRL_WIDTH];
  logic [CTRL_WIDTH-1:0] ctrl_d  [CTRL_WIDTH];
  logic [1:0]            mode_q  [CTRL_WIDTH];
  logic [1:0]            mode_d  [CTRL_WIDTH];

  // Stage inputs: stage 0 takes the port, stage k takes stage k-1's register.
  logic                  stg_valid [CTRL_WIDTH];
  logic [BW-1:0]         stg_data  [CTRL_WIDTH];
  logic [NUM_DATA-1:0]   stg_mask  [CTRL_WIDTH];
  logic [CTRL_WIDTH-1:0] stg_ctrl  [CTRL_WIDTH];
  logic [1:0]            stg_mode  [CTRL_WIDTH];

  assign advance   = !valid_q[CTRL_WIDTH-1] || OUT_READY;
  assign IN_READY  = advance;
  assign OUT_VALID = valid_q[CTRL_WIDTH-1];
  assign DATA_OUT  = data_q[CTRL_WIDTH-1];
  assign LANE_MASK = mask_q[CTRL_WIDTH-1];

  always_comb begin
    stg_valid[0] = IN_VALID;
    stg_data[0]  = DATA_IN;
    stg_mask[0]  = '1;
    stg_ctrl[0]  = CTRL_IN;
    stg_mode[0]  = MODE_IN;
    for (int unsigned k = 1; k < CTRL_WIDTH; k++) begin
      stg_valid[k] = valid_q[k-1];
      stg_data[k]  = data_q[k-1];
      stg_mask[k]  = mask_q[k-1];
      stg_ctrl[k]  = ctrl_q[k-1];
      stg_mode[k]  = mode_q[k-1];
    end
  end

  always_comb begin
    int unsigned sh;
    int unsigned src;
    logic        keep;
    sh   = 0;
    src  = 0;
    keep = 1'b0;
    for (int unsigned k = 0; k < CTRL_WIDTH; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      mask_d[k]  = mask_q[k];
      ctrl_d[k]  = ctrl_q[k];
      mode_d[k]  = mode_q[k];
      if (advance) begin
        valid_d[k] = stg_valid[k];
        ctrl_d[k]  = stg_ctrl[k];
        mode_d[k]  = stg_mode[k];
        data_d[k]  = '0;
        mask_d[k]  = '0;
        sh = stg_ctrl[k][k] ? (32'd1 << k) : 32'd0;
        for (int unsigned i = 0; i < NUM_DATA; i++) begin
          // Right-moving modes read upward lanes, left-moving ones downward; src is
          // always reduced mod NUM_DATA and the shift modes gate it with keep.
          if (stg_mode[k] == MODE_ROR || stg_mode[k] == MODE_SHR) begin
            src  = (i + sh) % NUM_DATA;
            keep = (stg_mode[k] == MODE_ROR) || ((i + sh) < NUM_DATA);
          end else begin
            src  = (i + NUM_DATA - sh) % NUM_DATA;
            keep = (stg_mode[k] == MODE_ROL) || (i >= sh);
          end
          if (keep) begin
            data_d[k][i*DATA_WIDTH +: DATA_WIDTH] = stg_data[k][src*DATA_WIDTH +: DATA_WIDTH];
            mask_d[k][i] = stg_mask[k][src];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      for (int unsigned k = 0; k < CTRL_WIDTH; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        mask_q[k]  <= '0;
        ctrl_q[k]  <= '0;
        mode_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < CTRL_WIDTH; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        mask_q[k]  <= mask_d[k];
        ctrl_q[k]  <= ctrl_d[k];
        mode_q[k]  <= mode_d[k];
      end
    end
  end

endmodule

// File: tb/tb_lane_rotator_pipe.sv
// Bench for lane_rotator_pipe: directed beats, backpressure, then randomized traffic
// with a mid-stream reset, all scored against a queue-based reference model.
module tb_lane_rotator_pipe;

  localparam int DW = 16;
  localparam int ND = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   data_in;
  logic [CW-1:0] ctrl_in;
  logic [1:0]    mode_in;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   data_out;
  logic [ND-1:0] lane_mask;

  int n_checks = 0;
  int n_pass   = 0;

  logic [67:0] exp_q [$];
  logic        chk_after_rst = 1'b0;

  lane_rotator_pipe #(.DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW)) dut (
    .ACLK      (clk),
    .RESET     (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .DATA_IN   (data_in),
    .CTRL_IN   (ctrl_in),
    .MODE_IN   (mode_in),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .DATA_OUT  (data_out),
    .LANE_MASK (lane_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Whole-offset reference: {mask, data} for offset c under mode m.
  function automatic logic [67:0] ref_beat(input logic [63:0] d, input int c, input logic [1:0] m);
    logic [127:0] dd;
    logic [63:0]  o;
    logic [3:0]   mk;
    logic [3:0]   ones;
    ones = 4'hF;
    dd   = {d, d};
    case (m)
      2'b00:   begin dd = dd >> (c * DW); o = dd[63:0];   mk = ones; end
      2'b01:   begin dd = dd << (c * DW); o = dd[127:64]; mk = ones; end
      2'b10:   begin o = d >> (c * DW); mk = ones >> c; end
      default: begin o = d << (c * DW); mk = ones << c; end
    endcase
    return {mk, o};
  endfunction

  // Scoreboard: handshakes seen at a negedge take effect at the following posedge.
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", data_out, e[63:0]);
          check("beat_mask", {60'd0, lane_mask}, {60'd0, e[67:64]});
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_beat(data_in, int'(ctrl_in), mode_in));
    end
  end

  task automatic directed(input string tag, input logic [1:0] m, input int c,
                          input logic [63:0] exp_d, input logic [3:0] exp_m);
    @(posedge clk); #1;
    in_valid = 1'b1;
    data_in  = 64'h0004_0003_0002_0001;
    ctrl_in  = CW'(c);
    mode_in  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_mask"}, {60'd0, lane_mask}, {60'd0, exp_m});
  endtask

  logic [63:0] bp_d [3];
  logic [1:0]  bp_m [3];
  int          bp_c [3];

  initial begin
    int          bp_idx;
    int          accepted;
    int          cycles;
    bit          acc;
    bit          did_rst;
    logic [67:0] e0;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; ctrl_in = '0; mode_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data_out", data_out, 64'd0);
    check("rst_lane_mask", {60'd0, lane_mask}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    out_ready = 1'b1;
    directed("ror1", 2'b00, 1, 64'h0001_0004_0003_0002, 4'b1111);
    directed("rol1", 2'b01, 1, 64'h0003_0002_0001_0004, 4'b1111);
    directed("shr1", 2'b10, 1, 64'h0000_0004_0003_0002, 4'b0111);
    directed("shl2", 2'b11, 2, 64'h0002_0001_0000_0000, 4'b1100);
    directed("shl0", 2'b11, 0, 64'h0004_0003_0002_0001, 4'b1111);
    directed("shr3", 2'b10, 3, 64'h0000_0000_0000_0004, 4'b0001);
    repeat (3) @(posedge clk);

    // Backpressure: three beats offered while the output is stalled.
    bp_d[0] = 64'h1111_2222_3333_4444; bp_m[0] = 2'b00; bp_c[0] = 3;
    bp_d[1] = 64'hAAAA_BBBB_CCCC_DDDD; bp_m[1] = 2'b11; bp_c[1] = 1;
    bp_d[2] = 64'h0F0F_F0F0_1234_5678; bp_m[2] = 2'b01; bp_c[2] = 2;
    e0 = ref_beat(bp_d[0], bp_c[0], bp_m[0]);
    @(posedge clk); #1;
    out_ready = 1'b0;
    bp_idx = 0;
    in_valid = 1'b1; data_in = bp_d[0]; mode_in = bp_m[0]; ctrl_in = CW'(bp_c[0]);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      if (cyc >= 3) check("bp_hold_data", data_out, e0[63:0]);
      @(posedge clk); #1;
      if (acc) begin
        bp_idx++;
        if (bp_idx < 3) begin
          data_in = bp_d[bp_idx]; mode_in = bp_m[bp_idx]; ctrl_in = CW'(bp_c[bp_idx]);
        end
      end
    end
    @(negedge clk);
    check("bp_accepted", 64'(bp_idx), 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check("bp_head_mask", {60'd0, lane_mask}, {60'd0, e0[67:64]});
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles = 0;
    while (bp_idx < 3 && cycles < 10) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) bp_idx++;
      cycles++;
    end
    in_valid = 1'b0;
    check("bp_third_accepted", 64'(bp_idx), 64'd3);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 10) begin
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with held-until-accepted inputs and random backpressure.
    accepted = 0;
    cycles   = 0;
    did_rst  = 1'b0;
    while (accepted < 10000 && cycles < 60000) begin
      @(negedge clk);
      if (chk_after_rst) begin
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_queue", 64'(exp_q.size()), 64'd0);
        chk_after_rst = 1'b0;
      end
      acc = in_valid && in_ready && !rst;
      @(posedge clk); #1;
      cycles++;
      if (acc) accepted++;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        data_in  = {$urandom, $urandom};
        ctrl_in  = CW'($urandom_range(0, 3));
        mode_in  = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (accepted >= 5000 && !did_rst) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        did_rst = 1'b1;
        chk_after_rst = 1'b1;
      end
    end
    check("rand_beats_accepted", 64'(accepted), 64'd10000);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 20) begin
      @(posedge clk);
      cycles++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_out_valid", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
